wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter NB_DATA, default 32, register-file data width.
REQ-002 Parameter NB_REG_ADDRESS, default 5, register address width.
REQ-003 Parameter MAX_STARVE, default 4, pipeline-won cycles tolerated before a pending debug write forces a stall; legal range 1..15.
REQ-004 i_clock  input  1  single clock; all state updates on rising edge.
REQ-005 i_reset  input  1  asynchronous, active-low reset.
REQ-006 i_wb_valid  input  1  pipeline write-back stage holds a write this cycle.
REQ-007 i_wb_data  input  NB_DATA  pipeline write-back data.
REQ-008 i_wb_address  input  NB_REG_ADDRESS  pipeline write-back destination register.
REQ-009 i_dbg_req  input  1  debug unit requests one register write; held until o_dbg_grant.
REQ-010 i_dbg_data  input  NB_DATA  debug write data, stable while i_dbg_req=1.
REQ-011 i_dbg_address  input  NB_REG_ADDRESS  debug destination register, stable while i_dbg_req=1.
REQ-012 o_rf_write_enable  output  1  register-file write strobe, registered.
REQ-013 o_rf_data  output  NB_DATA  register-file write data, registered.
REQ-014 o_rf_address  output  NB_REG_ADDRESS  register-file write address, registered.
REQ-015 o_pipe_stall  output  1  freezes the pipeline so debug can own the port, registered.
REQ-016 o_dbg_grant  output  1  one-cycle pulse: debug write committed, registered.
REQ-017 o_conflict  output  1  sticky flag: pipeline write arrived while the port was owned by debug.

Function
REQ-018 FSM states ST_PIPE, ST_STALL, ST_DBG; starve counter 4 bits.
REQ-019 Latency: every accepted write appears on o_rf_* exactly one cycle after its inputs are sampled.
REQ-020 ST_PIPE: o_pipe_stall=0; i_wb_valid=1 drives o_rf_write_enable=1 next cycle with i_wb_data/i_wb_address.
REQ-021 ST_PIPE, i_dbg_req=1, i_wb_valid=0: go to ST_DBG.
REQ-022 ST_PIPE, i_dbg_req=1, i_wb_valid=1: pipeline write taken, counter increments; when counter reaches MAX_STARVE, go to ST_STALL and set o_pipe_stall=1.
REQ-023 ST_STALL: o_pipe_stall=1; an in-flight i_wb_valid=1 write still commits; on first cycle with i_wb_valid=0 go to ST_DBG.
REQ-024 ST_STALL with i_dbg_req=0: return to ST_PIPE, clear o_pipe_stall and counter.
REQ-025 ST_DBG: o_pipe_stall stays 1; debug write drives o_rf_* next cycle, o_dbg_grant pulses with it; next state ST_PIPE, counter cleared, o_pipe_stall cleared.
REQ-026 ST_DBG with i_wb_valid=1: pipeline write wins the port, o_dbg_grant withheld, state stays ST_DBG, o_conflict set.
REQ-027 Writes to register 0, from either source: o_rf_write_enable=0, data/address still presented; debug write to register 0 still receives o_dbg_grant.
REQ-028 o_rf_write_enable=0 in any cycle with no accepted write; o_rf_data/o_rf_address hold their last values.
REQ-029 Counter saturates at MAX_STARVE and never wraps.
REQ-030 Debug request dropped in ST_DBG before commit: no write, no grant, return to ST_PIPE.

Reset
REQ-031 i_reset=0 asynchronously forces ST_PIPE, counter 0, all outputs 0, including o_conflict.
REQ-032 Reset mid-stall or mid-debug write aborts it without a write strobe or grant; after release the debug unit must re-request.
REQ-033 o_conflict clears only by reset.

Verification
REQ-034 Pipeline only: i_wb_valid=1, addr 5, data 0xDEADBEEF -> next cycle o_rf_write_enable=1, o_rf_address=5, o_rf_data=0xDEADBEEF, o_pipe_stall=0.
REQ-035 Idle-slot debug: i_wb_valid=0, i_dbg_req=1, addr 7, data 0x12345678 -> ST_DBG, then o_rf_write_enable=1, o_rf_address=7 with o_dbg_grant=1 for exactly one cycle.
REQ-036 Starvation: i_wb_valid=1 continuously with i_dbg_req=1, MAX_STARVE=4 -> o_pipe_stall rises after 4 pipeline writes; debug write commits on the first i_wb_valid=0 cycle; stall drops after the grant.
REQ-037 Register 0: pipeline write addr 0 -> o_rf_write_enable stays 0; debug write addr 0 -> o_dbg_grant=1, o_rf_write_enable=0.
REQ-038 Conflict: force i_wb_valid=1 while in ST_DBG -> pipeline write committed, no grant that cycle, o_conflict=1 and held until reset.
REQ-039 Reset in ST_STALL: assert i_reset=0 asynchronously -> all outputs 0 immediately; after release, o_pipe_stall=0 and no spurious grant.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the pipeline write-back stage and a debug unit.
// The pipeline normally wins; a starved debug write eventually stalls the pipeline.
module wb_port_arbiter #(
  parameter int unsigned NB_DATA        = 32,
  parameter int unsigned NB_REG_ADDRESS = 5,
  parameter int unsigned MAX_STARVE     = 4
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_wb_valid,
  input  logic [NB_DATA-1:0]        i_wb_data,
  input  logic [NB_REG_ADDRESS-1:0] i_wb_address,
  input  logic                      i_dbg_req,
  input  logic [NB_DATA-1:0]        i_dbg_data,
  input  logic [NB_REG_ADDRESS-1:0] i_dbg_address,
  output logic                      o_rf_write_enable,
  output logic [NB_DATA-1:0]        o_rf_data,
  output logic [NB_REG_ADDRESS-1:0] o_rf_address,
  output logic                      o_pipe_stall,
  output logic                      o_dbg_grant,
  output logic                      o_conflict
);

  typedef enum logic [1:0] {
    StPipe,
    StStall,
    StDbg
  } state_e;

  localparam logic [3:0] MaxStarve = 4'(MAX_STARVE);

  state_e                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic                        we_q, we_d;
  logic [NB_DATA-1:0]          data_q, data_d;
  logic [NB_REG_ADDRESS-1:0]   addr_q, addr_d;
  logic                        stall_q, stall_d;
  logic                        grant_q, grant_d;
  logic                        conflict_q, conflict_d;
  logic                        take_wb;
  logic                        take_dbg;

  // Next-state logic. The pipeline write is always accepted when valid; the
  // debug write is accepted only while the arbiter owns the port for debug.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    conflict_d = conflict_q;
    take_wb    = i_wb_valid;
    take_dbg   = 1'b0;

    case (state_q)
      StPipe: begin
        if (!i_dbg_req) begin
          cnt_d = '0;
        end else if (!i_wb_valid) begin
          state_d = StDbg;
        end else begin
          cnt_d = (cnt_q >= MaxStarve) ? cnt_q : cnt_q + 4'd1;
          if (cnt_d >= MaxStarve) begin
            state_d = StStall;
          end
        end
      end

      StStall: begin
        if (!i_dbg_req) begin
          state_d = StPipe;
          cnt_d   = '0;
        end else if (!i_wb_valid) begin
          state_d = StDbg;
        end
      end

      StDbg: begin
        // A pipeline write here means the pipeline ignored the stall.
        if (i_wb_valid) begin
          conflict_d = 1'b1;
        end
        if (!i_dbg_req) begin
          state_d = StPipe;
          cnt_d   = '0;
        end else if (!i_wb_valid) begin
          take_dbg = 1'b1;
          state_d  = StPipe;
          cnt_d    = '0;
        end
      end

      default: begin
        state_d = StPipe;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered port drive; register 0 is never strobed but data/address still update.
  always_comb begin
    we_d    = 1'b0;
    data_d  = data_q;
    addr_d  = addr_q;
    grant_d = take_dbg;
    stall_d = (state_d != StPipe);

    if (take_wb) begin
      data_d = i_wb_data;
      addr_d = i_wb_address;
      we_d   = |i_wb_address;
    end else if (take_dbg) begin
      data_d = i_dbg_data;
      addr_d = i_dbg_address;
      we_d   = |i_dbg_address;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= StPipe;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      stall_q    <= 1'b0;
      grant_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      stall_q    <= stall_d;
      grant_q    <= grant_d;
      conflict_q <= conflict_d;
    end
  end

  assign o_rf_write_enable = we_q;
  assign o_rf_data         = data_q;
  assign o_rf_address      = addr_q;
  assign o_pipe_stall      = stall_q;
  assign o_dbg_grant       = grant_q;
  assign o_conflict        = conflict_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized self-checking bench for wb_port_arbiter against a port-ownership model.
module tb_wb_port_arbiter;

  localparam int unsigned NbData = 32;
  localparam int unsigned NbAddr = 5;
  localparam int unsigned MaxSt  = 4;

  logic              i_clock = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_wb_valid = 1'b0;
  logic [NbData-1:0] i_wb_data = '0;
  logic [NbAddr-1:0] i_wb_address = '0;
  logic              i_dbg_req = 1'b0;
  logic [NbData-1:0] i_dbg_data = '0;
  logic [NbAddr-1:0] i_dbg_address = '0;
  logic              o_rf_write_enable;
  logic [NbData-1:0] o_rf_data;
  logic [NbAddr-1:0] o_rf_address;
  logic              o_pipe_stall;
  logic              o_dbg_grant;
  logic              o_conflict;

  wb_port_arbiter #(
    .NB_DATA        (NbData),
    .NB_REG_ADDRESS (NbAddr),
    .MAX_STARVE     (MaxSt)
  ) dut (
    .i_clock           (i_clock),
    .i_reset           (i_reset),
    .i_wb_valid        (i_wb_valid),
    .i_wb_data         (i_wb_data),
    .i_wb_address      (i_wb_address),
    .i_dbg_req         (i_dbg_req),
    .i_dbg_data        (i_dbg_data),
    .i_dbg_address     (i_dbg_address),
    .o_rf_write_enable (o_rf_write_enable),
    .o_rf_data         (o_rf_data),
    .o_rf_address      (o_rf_address),
    .o_pipe_stall      (o_pipe_stall),
    .o_dbg_grant       (o_dbg_grant),
    .o_conflict        (o_conflict)
  );

  always #5 i_clock = ~i_clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the port, whether the pipeline is held, how many
  // times a pending debug write has lost, and the expected port outputs.
  bit              m_dbg_owns;
  bit              m_held;
  int              m_losses;
  bit              m_conflict;
  bit              e_we;
  bit [NbData-1:0] e_data;
  bit [NbAddr-1:0] e_addr;
  bit              e_grant;
  bit              e_stall;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dbg_owns = 0; m_held = 0; m_losses = 0; m_conflict = 0;
    e_we = 0; e_data = '0; e_addr = '0; e_grant = 0; e_stall = 0;
  endtask

  task automatic model_step();
    bit dbg_commit;
    dbg_commit = m_dbg_owns && i_dbg_req && !i_wb_valid;
    e_we    = 0;
    e_grant = dbg_commit;
    if (i_wb_valid) begin
      e_data = i_wb_data; e_addr = i_wb_address; e_we = (i_wb_address != 0);
    end else if (dbg_commit) begin
      e_data = i_dbg_data; e_addr = i_dbg_address; e_we = (i_dbg_address != 0);
    end
    if (m_dbg_owns) begin
      if (i_wb_valid) m_conflict = 1;
      if (!i_dbg_req || dbg_commit) begin
        m_dbg_owns = 0; m_held = 0; m_losses = 0;
      end
    end else if (m_held) begin
      if (!i_dbg_req) begin
        m_held = 0; m_losses = 0;
      end else if (!i_wb_valid) begin
        m_dbg_owns = 1;
      end
    end else if (!i_dbg_req) begin
      m_losses = 0;
    end else if (!i_wb_valid) begin
      m_dbg_owns = 1;
    end else begin
      m_losses = (m_losses < MaxSt) ? m_losses + 1 : MaxSt;
      if (m_losses == MaxSt) m_held = 1;
    end
    e_stall = m_held || m_dbg_owns;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_we"}, o_rf_write_enable, e_we);
    check_eq({tag, "_data"}, o_rf_data, e_data);
    check_eq({tag, "_addr"}, o_rf_address, e_addr);
    check_eq({tag, "_stall"}, o_pipe_stall, e_stall);
    check_eq({tag, "_grant"}, o_dbg_grant, e_grant);
    check_eq({tag, "_conflict"}, o_conflict, m_conflict);
  endtask

  // One clock: inputs already set are sampled at the edge, outputs checked #1 later.
  task automatic cycle(input string tag);
    @(posedge i_clock);
    #1;
    model_step();
    check_all(tag);
  endtask

  task automatic set_wb(input bit v, input logic [NbAddr-1:0] a, input logic [NbData-1:0] d);
    i_wb_valid = v; i_wb_address = a; i_wb_data = d;
  endtask

  task automatic set_dbg(input bit r, input logic [NbAddr-1:0] a, input logic [NbData-1:0] d);
    i_dbg_req = r; i_dbg_address = a; i_dbg_data = d;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_we"}, o_rf_write_enable, 0);
    check_eq({tag, "_data"}, o_rf_data, 0);
    check_eq({tag, "_addr"}, o_rf_address, 0);
    check_eq({tag, "_stall"}, o_pipe_stall, 0);
    check_eq({tag, "_grant"}, o_dbg_grant, 0);
    check_eq({tag, "_conflict"}, o_conflict, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge i_clock);
    #1;
    check_zero("reset");
    @(negedge i_clock);
    i_reset = 1'b1;

    // Plain pipeline write.
    set_wb(1, 5'd5, 32'hDEADBEEF);
    cycle("pipe");
    check_eq("pipe_lit_we", o_rf_write_enable, 1);
    check_eq("pipe_lit_addr", o_rf_address, 5);
    check_eq("pipe_lit_data", o_rf_data, 32'hDEADBEEF);
    check_eq("pipe_lit_stall", o_pipe_stall, 0);

    // Debug write into an idle slot.
    set_wb(0, 5'd0, '0);
    set_dbg(1, 5'd7, 32'h12345678);
    cycle("idle_dbg0");
    check_eq("idle_dbg0_lit_we", o_rf_write_enable, 0);
    check_eq("idle_dbg0_lit_stall", o_pipe_stall, 1);
    cycle("idle_dbg1");
    check_eq("idle_dbg1_lit_we", o_rf_write_enable, 1);
    check_eq("idle_dbg1_lit_addr", o_rf_address, 7);
    check_eq("idle_dbg1_lit_grant", o_dbg_grant, 1);
    set_dbg(0, 5'd0, '0);
    cycle("idle_dbg2");
    check_eq("idle_dbg2_lit_grant", o_dbg_grant, 0);

    // Starvation: four pipeline wins, then stall.
    set_dbg(1, 5'd9, 32'hA5A5_0009);
    for (int i = 0; i < 4; i++) begin
      set_wb(1, 5'(i + 1), 32'h100 + i);
      cycle("starve");
      check_eq("starve_lit_stall", o_pipe_stall, (i == 3) ? 1 : 0);
    end
    set_wb(1, 5'd12, 32'h0000_0BAD);
    cycle("stall_inflight");
    check_eq("stall_inflight_lit_we", o_rf_write_enable, 1);
    set_wb(0, 5'd0, '0);
    cycle("stall_to_dbg");
    cycle("stall_commit");
    check_eq("stall_commit_lit_grant", o_dbg_grant, 1);
    check_eq("stall_commit_lit_addr", o_rf_address, 9);
    check_eq("stall_commit_lit_stall", o_pipe_stall, 0);
    set_dbg(0, 5'd0, '0);
    cycle("stall_after");

    // Register 0 from both sources.
    set_wb(1, 5'd0, 32'h0BAD_0000);
    cycle("r0_pipe");
    check_eq("r0_pipe_lit_we", o_rf_write_enable, 0);
    set_wb(0, 5'd0, '0);
    set_dbg(1, 5'd0, 32'h0000_1111);
    cycle("r0_dbg0");
    cycle("r0_dbg1");
    check_eq("r0_dbg1_lit_grant", o_dbg_grant, 1);
    check_eq("r0_dbg1_lit_we", o_rf_write_enable, 0);
    set_dbg(0, 5'd0, '0);
    cycle("r0_after");

    // Random traffic; debug holds its request until granted, rarely abandons it.
    for (int n = 0; n < 3000; n++) begin
      if (i_dbg_req && e_grant) begin
        set_dbg(0, i_dbg_address, i_dbg_data);
      end else if (i_dbg_req && ($urandom_range(0, 39) == 0)) begin
        set_dbg(0, i_dbg_address, i_dbg_data);
      end else if (!i_dbg_req && ($urandom_range(0, 3) == 0)) begin
        set_dbg(1, 5'($urandom_range(0, 31)), $urandom);
      end
      if (e_stall) set_wb($urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), $urandom);
      else set_wb($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom);
      cycle("rand");
    end

    // Reset then force a conflict during a debug-owned slot.
    @(negedge i_clock);
    set_wb(0, 5'd0, '0);
    set_dbg(0, 5'd0, '0);
    i_reset = 1'b0;
    #1;
    model_reset();
    check_zero("rst_mid");
    @(negedge i_clock);
    i_reset = 1'b1;
    set_dbg(1, 5'd3, 32'h3333_3333);
    cycle("conf0");
    set_wb(1, 5'd4, 32'h4444_4444);
    cycle("conf1");
    check_eq("conf1_lit_we", o_rf_write_enable, 1);
    check_eq("conf1_lit_grant", o_dbg_grant, 0);
    check_eq("conf1_lit_conflict", o_conflict, 1);
    set_wb(0, 5'd0, '0);
    cycle("conf2");
    check_eq("conf2_lit_grant", o_dbg_grant, 1);
    set_dbg(0, 5'd0, '0);
    repeat (3) cycle("conf_hold");
    check_eq("conf_hold_lit", o_conflict, 1);

    // Asynchronous reset while stalled.
    set_dbg(1, 5'd11, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) begin
      set_wb(1, 5'd2, 32'h200 + i);
      cycle("rst_starve");
    end
    check_eq("rst_starve_lit_stall", o_pipe_stall, 1);
    #2;
    i_reset = 1'b0;
    #1;
    model_reset();
    check_zero("rst_async");
    set_wb(0, 5'd0, '0);
    set_dbg(0, 5'd0, '0);
    @(negedge i_clock);
    i_reset = 1'b1;
    repeat (3) begin
      cycle("rst_after");
      check_eq("rst_after_lit_stall", o_pipe_stall, 0);
      check_eq("rst_after_lit_grant", o_dbg_grant, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
